// File: rtl/prog_loader_pkg.sv
// Shared types and frame constants for the program loader.
package prog_loader_pkg;

    localparam int LEN_W  = 16;
    localparam int WORD_W = 32;
    localparam int CSUM_W = 8;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_WRITE,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    // Word count larger than the instruction memory can hold.
    function automatic logic len_too_big(input logic [LEN_W-1:0] n, input int addr_w);
        return 32'(n) > (32'd1 << addr_w);
    endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Big-endian 4-byte word assembler; word_ready flags the byte that completes a word.
module byte_packer
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              Reset,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_ready
);

    logic [23:0] acc;
    logic [1:0]  cnt;

    // The completing byte is folded in combinationally so the word is usable in the same cycle.
    assign word       = {acc, byte_in};
    assign word_ready = shift_en && (cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (!Reset || clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (shift_en) begin
            acc <= {acc[15:0], byte_in};
            cnt <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader into instruction memory; holds the CPU until a frame checks clean.
//   state  | meaning
//   IDLE   | waiting for MAGIC, other bytes dropped
//   LEN_HI | word count high byte
//   LEN_LO | word count low byte, range check
//   DATA   | collecting word bytes, running XOR
//   WRITE  | one-cycle memory write, input stalled
//   CSUM   | compare checksum byte
//   DONE   | loaded, CPU released
//   ERR    | rejected, CPU held
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         ADDR_W = 8,
    parameter logic [7:0] MAGIC  = MAGIC_DEFAULT
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    state_t            state;
    logic [LEN_W-1:0]  len;
    logic [CSUM_W-1:0] csum;
    logic [ADDR_W:0]   idx;

    logic              accept;
    logic              restart;
    logic              pk_shift;
    logic              pk_ready;
    logic [WORD_W-1:0] pk_word;
    logic [LEN_W-1:0]  len_rx;
    logic [ADDR_W:0]   idx_inc;

    assign accept   = rx_valid && rx_ready;
    assign restart  = accept && (rx_data == MAGIC) &&
                      (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    assign pk_shift = accept && (state == ST_DATA);
    assign len_rx   = {len[LEN_W-1:8], rx_data};
    assign idx_inc  = idx + (ADDR_W+1)'(1);

    byte_packer u_packer (
        .clk        (clk),
        .Reset      (Reset),
        .clear      (restart),
        .shift_en   (pk_shift),
        .byte_in    (rx_data),
        .word       (pk_word),
        .word_ready (pk_ready)
    );

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state    <= ST_IDLE;
            len      <= '0;
            csum     <= '0;
            idx      <= '0;
            rx_ready <= 1'b1;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            wr_en    <= 1'b0;
            rx_ready <= 1'b1;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (restart) begin
                        state    <= ST_LEN_HI;
                        len      <= '0;
                        csum     <= '0;
                        idx      <= '0;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        cpu_hold <= 1'b1;
                    end
                end
                ST_LEN_HI: begin
                    if (accept) begin
                        len[LEN_W-1:8] <= rx_data;
                        state          <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (accept) begin
                        len <= len_rx;
                        if (len_rx == '0) begin
                            state <= ST_CSUM;
                        end else if (len_too_big(len_rx, ADDR_W)) begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        csum <= csum ^ rx_data;
                        if (pk_ready) begin
                            state    <= ST_WRITE;
                            wr_en    <= 1'b1;
                            wr_data  <= pk_word;
                            wr_addr  <= idx[ADDR_W-1:0];
                            rx_ready <= 1'b0;
                        end
                    end
                end
                ST_WRITE: begin
                    // Counter is one bit wider than the address so a full memory terminates cleanly.
                    idx   <= idx_inc;
                    state <= (32'(idx_inc) == 32'(len)) ? ST_CSUM : ST_DATA;
                end
                ST_CSUM: begin
                    if (accept) begin
                        if (rx_data == csum) begin
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames, checksum errors, length limits, mid-frame reset, streaming.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        Reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0]  wq_addr[$];
    logic [31:0] wq_data[$];

    prog_loader #(.ADDR_W(8), .MAGIC(8'hA5)) dut (
        .clk      (clk),
        .Reset    (Reset),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
        end
    end

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send(input logic [7:0] b);
        int guard;
        rx_valid = 1'b1;
        rx_data  = b;
        guard    = 0;
        while (rx_ready !== 1'b1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 10) begin
            n_cmp++; n_mis++;
            $display("FAIL send_stall: rx_ready stuck at %b, required 1", rx_ready);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        Reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({cpu_hold, rx_ready, wr_en, done, err} !== 5'b11000) begin
            n_mis++;
            $display("FAIL reset_flags: got %b, required 11000", {cpu_hold, rx_ready, wr_en, done, err});
        end
        n_cmp++;
        if ({wr_addr, wr_data} !== 40'h0) begin
            n_mis++;
            $display("FAIL reset_wr_bus: got %h, required 0", {wr_addr, wr_data});
        end
        Reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_good_frame();
        wq_addr.delete(); wq_data.delete();
        send(8'hA5); send(8'h00); send(8'h02);
        send(8'h12); send(8'h34); send(8'h56); send(8'h78);
        n_cmp++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 8'h00, 32'h12345678}) begin
            n_mis++;
            $display("FAIL write_latency: got en=%b addr=%h data=%h, required 1/00/12345678", wr_en, wr_addr, wr_data);
        end
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        n_cmp++;
        if ({cpu_hold, done, err} !== 3'b100) begin
            n_mis++;
            $display("FAIL good_hold_before_csum: got %b, required 100", {cpu_hold, done, err});
        end
        send(8'h2A);
        n_cmp++;
        if ({cpu_hold, done, err} !== 3'b010) begin
            n_mis++;
            $display("FAIL good_done: hold/done/err got %b, required 010", {cpu_hold, done, err});
        end
        n_cmp++;
        if (wq_addr.size() != 2 || wq_addr[0] !== 8'h00 || wq_data[0] !== 32'h12345678 ||
            wq_addr[1] !== 8'h01 || wq_data[1] !== 32'hDEADBEEF) begin
            n_mis++;
            $display("FAIL good_writes: got n=%0d %h@%h %h@%h, required 2 12345678@00 deadbeef@01",
                     wq_addr.size(), wq_data[0], wq_addr[0], wq_data[1], wq_addr[1]);
        end
    endtask

    task automatic test_bad_csum();
        wq_addr.delete(); wq_data.delete();
        send(8'hA5);
        n_cmp++;
        if ({cpu_hold, done} !== 2'b10) begin
            n_mis++;
            $display("FAIL restart_hold: hold/done got %b, required 10", {cpu_hold, done});
        end
        send(8'h00); send(8'h02);
        send(8'h12); send(8'h34); send(8'h56); send(8'h78);
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        send(8'h00);
        n_cmp++;
        if ({cpu_hold, done, err} !== 3'b101) begin
            n_mis++;
            $display("FAIL bad_csum_err: hold/done/err got %b, required 101", {cpu_hold, done, err});
        end
        n_cmp++;
        if (wq_data.size() != 2 || wq_data[0] !== 32'h12345678 || wq_data[1] !== 32'hDEADBEEF) begin
            n_mis++;
            $display("FAIL bad_csum_writes: got n=%0d, required 2 words", wq_data.size());
        end
        send(8'hA5); send(8'h00); send(8'h01);
        send(8'hCA); send(8'hFE); send(8'hBA); send(8'hBE); send(8'h30);
        n_cmp++;
        if ({cpu_hold, done, err} !== 3'b010) begin
            n_mis++;
            $display("FAIL recover_after_err: hold/done/err got %b, required 010", {cpu_hold, done, err});
        end
    endtask

    task automatic test_lengths();
        wq_addr.delete(); wq_data.delete();
        send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
        n_cmp++;
        if ({done, err, wq_data.size() == 0} !== 3'b101) begin
            n_mis++;
            $display("FAIL zero_len: done/err/nowrites got %b, required 101", {done, err, wq_data.size() == 0});
        end
        send(8'hA5); send(8'h01); send(8'h01);
        n_cmp++;
        if ({done, err, cpu_hold} !== 3'b011) begin
            n_mis++;
            $display("FAIL len_too_big: done/err/hold got %b, required 011", {done, err, cpu_hold});
        end
        send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
        n_cmp++;
        if (err !== 1'b1 || wq_data.size() != 0) begin
            n_mis++;
            $display("FAIL err_discard: err=%b writes=%0d, required 1 and 0", err, wq_data.size());
        end
    endtask

    task automatic test_reset_mid();
        wq_addr.delete(); wq_data.delete();
        send(8'hA5); send(8'h00); send(8'h01); send(8'h12); send(8'h34);
        Reset = 1'b0;
        @(negedge clk);
        Reset = 1'b1;
        n_cmp++;
        if ({cpu_hold, rx_ready, wr_en, done, err} !== 5'b11000) begin
            n_mis++;
            $display("FAIL mid_reset_state: got %b, required 11000", {cpu_hold, rx_ready, wr_en, done, err});
        end
        repeat (6) @(negedge clk);
        n_cmp++;
        if (wq_data.size() != 0) begin
            n_mis++;
            $display("FAIL mid_reset_nowrite: got %0d writes, required 0", wq_data.size());
        end
        send(8'h00); send(8'hFF);
        send(8'hA5); send(8'h00); send(8'h01);
        send(8'hCA); send(8'hFE); send(8'hBA); send(8'hBE); send(8'h30);
        n_cmp++;
        if (wq_data.size() != 1 || wq_addr[0] !== 8'h00 || wq_data[0] !== 32'hCAFEBABE || done !== 1'b1) begin
            n_mis++;
            $display("FAIL after_reset_frame: n=%0d %h@%h done=%b, required 1 cafebabe@00 done=1",
                     wq_data.size(), wq_data[0], wq_addr[0], done);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  bytes[16];
        logic [31:0] exp_w[3];
        int idx, lows, bad;
        bytes = '{8'hA5, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                  8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0C};
        exp_w = '{32'h01020304, 32'h05060708, 32'h090A0B0C};
        wq_addr.delete(); wq_data.delete();
        idx = 0; lows = 0; bad = 0;
        for (int cyc = 0; cyc < 100 && idx < 16; cyc++) begin
            rx_valid = 1'b1;
            rx_data  = bytes[idx];
            if (rx_ready !== ~wr_en) bad++;
            if (rx_ready !== 1'b1) lows++;
            else idx++;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        n_cmp++;
        if (bad != 0 || lows != 3) begin
            n_mis++;
            $display("FAIL stream_ready: bad=%0d low_cycles=%0d, required 0 and 3", bad, lows);
        end
        n_cmp++;
        if (wq_data.size() != 3 || done !== 1'b1) begin
            n_mis++;
            $display("FAIL stream_count: writes=%0d done=%b, required 3 and 1", wq_data.size(), done);
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (wq_data[k] !== exp_w[k] || wq_addr[k] !== 8'(k)) begin
                n_mis++;
                $display("FAIL stream_word%0d: got %h@%h, required %h@%h", k, wq_data[k], wq_addr[k], exp_w[k], 8'(k));
            end
        end
    endtask

    initial begin
        Reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_lengths();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
